// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM state encoding,
// frame-configuration field positions and the parity helper.
package uart_pkg;

    localparam int UART_CFG_W = 5;

    // cfg field positions
    localparam int CFG_DBITS_LSB    = 0;
    localparam int CFG_STOP_BIT     = 2;
    localparam int CFG_PAR_EN_BIT   = 3;
    localparam int CFG_PAR_TYPE_BIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP1  = 3'd5,
        ST_STOP2  = 3'd6
    } uart_tx_state_t;

    // Parity over the low (5 + dbits) bits only; odd inverts the XOR.
    function automatic logic uart_parity(input logic [7:0] data,
                                         input logic [1:0] dbits,
                                         input logic       odd);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - dbits);
        return (^(data & mask)) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 while run is high, held at 0 otherwise.
// Used by uart_tx_ctrl only when UART_TX_INT_BAUD_EN is defined.
module uart_baud_gen #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic run,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a frame on a start_tx rising edge and serialises it.
// Build option UART_TX_INT_BAUD_EN selects an internal CLK_DIV divider instead of baud_tick.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  baud_tick,
    input  logic [7:0]            tx_data,
    input  logic [UART_CFG_W-1:0] cfg,
    input  logic                  start_tx,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    uart_tx_state_t        state_q, state_d;
    logic                  start_q;
    logic [7:0]            data_q, data_d;
    logic [UART_CFG_W-1:0] cfg_q, cfg_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic       req;
    logic       tick;
    logic       run;
    logic [2:0] cnt_nx;
    logic [2:0] last_bit;

    assign req      = start_tx & ~start_q;
    assign run      = (state_q != ST_IDLE);
    assign cnt_nx   = cnt_q + 3'd1;
    assign last_bit = {1'b1, cfg_q[CFG_DBITS_LSB +: 2]};

`ifdef UART_TX_INT_BAUD_EN
    logic unused_baud;
    assign unused_baud = baud_tick;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .pclk    (pclk),
        .presetn (presetn),
        .run     (run),
        .tick    (tick)
    );
`else
    logic unused_div;
    assign unused_div = (CLK_DIV > 1);
    assign tick       = baud_tick;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = done_q;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                // a tick in the accept cycle is deliberately ignored
                if (req) begin
                    data_d  = tx_data;
                    cfg_d   = cfg;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    cnt_d   = 3'd0;
                    tx_d    = data_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (cnt_q == last_bit) begin
                        cnt_d = 3'd0;
                        if (cfg_q[CFG_PAR_EN_BIT]) begin
                            state_d = ST_PARITY;
                            tx_d    = uart_parity(data_q, cfg_q[CFG_DBITS_LSB +: 2],
                                                  cfg_q[CFG_PAR_TYPE_BIT]);
                        end else begin
                            state_d = ST_STOP1;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_nx;
                        tx_d  = data_q[cnt_nx];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP1;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP1: begin
                if (tick) begin
                    if (cfg_q[CFG_STOP_BIT]) begin
                        state_d = ST_STOP2;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            data_q  <= '0;
            cfg_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_tx;
            data_q  <= data_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule
